// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the load/store issuer and dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder; response WAIT_CYCLES+1 cycles after accept, held until rsp_ready.
// One request in flight; DMEM_ACCESS_CNT_EN adds saturating rd_count/wr_count outputs.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
`endif
);

  localparam bit       ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam bit [3:0] CNT_INIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [2**ADDR_W];

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              access;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       rd_val;
  logic              mem_wr;

  // With zero wait states the access happens on the accept edge, so it must use the live bus.
  always_comb begin
    cur_we    = (state == S_IDLE) ? bus.req_we    : lat_we;
    cur_addr  = (state == S_IDLE) ? bus.req_addr  : lat_addr;
    cur_wdata = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
    access    = ((state == S_IDLE) && bus.req_valid && ZERO_WAIT) ||
                ((state == S_WAIT) && (cnt == 4'd0));
    acc_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_W+2] != '0);
    acc_idx   = cur_addr[ADDR_W+1:2];
    rd_val    = (!cur_we && !acc_err) ? mem[acc_idx] : 32'd0;
    mem_wr    = rst && access && cur_we && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[acc_idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (ZERO_WAIT) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_val;
              rsp_err_q   <= acc_err;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_val;
            rsp_err_q   <= acc_err;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if ((state == S_RESP) && bus.rsp_ready && !rsp_err_q) begin
      if (lat_we) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model; also covers a zero-wait instance.
module tb_dmem_responder;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_count(rd_count), .wr_count(wr_count));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .rd_count(rd_count0), .wr_count(wr_count0));
`else
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_mem [256];
  int exp_rd_cnt = 0;
  int exp_wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: 256 words, byte address must be word aligned and below 1024.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input logic poke);
    logic        err;
    logic [7:0]  idx;
    logic [31:0] exp_rd;
    int          n;
    err    = ((addr % 4) != 0) || (addr >= 32'd1024);
    idx    = 8'(addr / 4);
    exp_rd = (!we && !err) ? ref_mem[idx] : 32'd0;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    if (we && !err) ref_mem[idx] = wdata;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(WAIT_CYCLES + 1));
    chk("rsp_err", 32'(bus.rsp_err), 32'(err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'($urandom_range(0, 255)) * 4;
        bus.req_wdata = $urandom;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_rdata", bus.rsp_rdata, 32'd0);
    chk("done_err", 32'(bus.rsp_err), 32'd0);
    chk("done_req_ready", 32'(bus.req_ready), 32'd1);
    if (!err) begin
      if (we) exp_wr_cnt++;
      else    exp_rd_cnt++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, old;
    int sel;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_rdata", bus.rsp_rdata, 32'd0);
    chk("post_rst_err", 32'(bus.rsp_err), 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
`endif

    for (int i = 0; i < 256; i++) txn(1'b1, 32'(i) * 4, $urandom, 0, 1'b0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h12, 32'h0, 0, 1'b0);
    txn(1'b1, 32'h400, 32'h12345678, 0, 1'b0);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 5, 1'b1);
    txn(1'b0, 32'h3FC, 32'h0, 0, 1'b0);

    // Reset while a store is still waiting: the store must be dropped.
    old = ref_mem[8];
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    @(posedge clk); #1;
    chk("midrst_model_untouched", ref_mem[8], old);
    txn(1'b0, 32'h20, 32'h0, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 32'($urandom_range(0, 255)) * 4;
      else if (sel < 9) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else              a = $urandom | 32'h400;
      d = $urandom;
      txn(1'($urandom), a, d, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Zero wait-state instance: one store then two loads of the same word.
    d = $urandom;
    for (int k = 0; k < 3; k++) begin
      bus0.req_valid = 1'b1;
      bus0.req_we    = (k == 0);
      bus0.req_addr  = 32'h44;
      bus0.req_wdata = d;
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      bus0.req_wdata = ~d;
      chk("zw_latency_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("zw_err", 32'(bus0.rsp_err), 32'd0);
      chk("zw_rdata", bus0.rsp_rdata, (k == 0) ? 32'd0 : d);
      bus0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus0.rsp_ready = 1'b0;
      chk("zw_done_valid", 32'(bus0.rsp_valid), 32'd0);
    end

`ifdef DMEM_ACCESS_CNT_EN
    chk("rd_count", 32'(rd_count), 32'(exp_rd_cnt));
    chk("wr_count", 32'(wr_count), 32'(exp_wr_cnt));
    chk("zw_rd_count", 32'(rd_count0), 32'd2);
    chk("zw_wr_count", 32'(wr_count0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
